logic_shift_unit: RTL

//  Multi-cycle bitwise-logic and shift engine for the MIPS ALU path.
//  - Takes operands from the decode/register stage over a valid/ready request channel.
//  - Returns the result over a valid/ready response channel.
//  - All logic ops are strictly bitwise (per-bit AND/OR/XOR/NOR), never logical reductions.
//  - Shifts are performed iteratively, SHIFT_STEP bits per cycle, to save area.

---
 rtl/logic_shift_unit_if.sv | 29 ++
 rtl/logic_shift_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/logic_shift_unit_if.sv
// Request/response bundle for logic_shift_unit.
// Request channel: in_valid/in_ready carrying op, a, b, shamt.
// Response channel: out_valid/out_ready carrying result and zero.
// master = requester and result consumer, slave = the logic/shift unit.
interface logic_shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/logic_shift_unit.sv
// Purpose: bitwise AND/OR/XOR/NOR, LUI and iterative SLL/SRL/SRA engine for the ALU path.
// Latency: 1 cycle for logic ops, LUI and zero-amount shifts; 1 + ceil(shamt/SHIFT_STEP) for shifts.
// Backpressure: one operation in flight; in_ready low until the result is taken with out_ready.
// Ports: clk, reset (async, active high), bus (slave modport of logic_shift_unit_if):
//   in_valid/in_ready/op/a/b/shamt request, out_valid/out_ready/result/zero response.
module logic_shift_unit #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter int SHIFT_STEP = 1
) (
  input logic               clk,
  input logic               reset,
  logic_shift_unit_if.slave bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_LUI = 3'b111;

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Captured shift control; fill is the sign of the original operand so SRA
  // keeps replicating it regardless of what the accumulator holds.
  typedef struct packed {
    logic [2:0] op;
    logic       fill;
  } shift_ctl_t;

  state_e             state;
  shift_ctl_t         ctl;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   result_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [SHAMT_W-1:0] step;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   imm_res;
  logic               is_shift;

  // Last step may be shorter than SHIFT_STEP.
  assign step      = (cnt < STEP) ? cnt : STEP;
  // Ones in the top 'step' bit positions vacated by a right shift.
  assign fill_mask = ~({WIDTH{1'b1}} >> step);

  always_comb begin
    acc_next = acc;
    case (ctl.op)
      OP_SLL:  acc_next = acc << step;
      OP_SRL:  acc_next = acc >> step;
      OP_SRA:  acc_next = (acc >> step) | (ctl.fill ? fill_mask : '0);
      default: acc_next = acc;
    endcase
  end

  // Single-cycle result; for shifts it is only used when shamt == 0.
  always_comb begin
    imm_res = '0;
    case (bus.op)
      OP_AND:  imm_res = bus.a & bus.b;
      OP_OR:   imm_res = bus.a | bus.b;
      OP_XOR:  imm_res = bus.a ^ bus.b;
      OP_NOR:  imm_res = ~(bus.a | bus.b);
      OP_LUI:  imm_res = {bus.b[15:0], {(WIDTH-16){1'b0}}};
      default: imm_res = bus.a;
    endcase
  end

  assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ctl         <= '0;
      acc         <= '0;
      cnt         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Held low during reset, so it rises on the first edge after release.
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            ctl        <= '{op: bus.op, fill: bus.a[WIDTH-1]};
            if (is_shift && (bus.shamt != '0)) begin
              acc   <= bus.a;
              cnt   <= bus.shamt;
              state <= SHIFT;
            end else begin
              result_q    <= imm_res;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - step;
          if (cnt == step) begin
            result_q    <= acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  // Derived from the registered result so it can never reflect live inputs.
  assign bus.zero      = (result_q == '0);

endmodule
